// File: rtl/multicycle_sequencer_pkg.sv
// Shared opcode, state and ALU-option definitions for the multi-cycle CPU sequencer.
package multicycle_sequencer_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    FETCH     = 3'd1,
    DECODE    = 3'd2,
    EXECUTE   = 3'd3,
    MEMORY    = 3'd4,
    WRITEBACK = 3'd5,
    ERROR     = 3'd7
  } state_e;

  localparam logic [3:0] OP_AND  = 4'd0;
  localparam logic [3:0] OP_ANDI = 4'd1;
  localparam logic [3:0] OP_ADD  = 4'd2;
  localparam logic [3:0] OP_ADDI = 4'd3;
  localparam logic [3:0] OP_OR   = 4'd4;
  localparam logic [3:0] OP_ORI  = 4'd5;
  localparam logic [3:0] OP_XOR  = 4'd6;
  localparam logic [3:0] OP_XORI = 4'd7;
  localparam logic [3:0] OP_LD   = 4'd8;
  localparam logic [3:0] OP_ST   = 4'd9;
  localparam logic [3:0] OP_JUMP = 4'd10;
  localparam logic [3:0] OP_BEQ  = 4'd11;
  localparam logic [3:0] OP_BGT  = 4'd12;
  localparam logic [3:0] OP_BLT  = 4'd13;
  localparam logic [3:0] OP_BGE  = 4'd14;
  localparam logic [3:0] OP_BLE  = 4'd15;

  localparam logic [1:0] ALU_AND = 2'b00;
  localparam logic [1:0] ALU_ADD = 2'b01;
  localparam logic [1:0] ALU_OR  = 2'b10;
  localparam logic [1:0] ALU_XOR = 2'b11;

  // The lower half of the opcode space is the register/immediate ALU group.
  function automatic logic is_alu_op(input logic [3:0] op);
    return ~op[3];
  endfunction

endpackage

// File: rtl/multicycle_sequencer_seq_branch_eval.sv
// Combinational branch condition: opcode plus ALU compare flags -> taken.
module seq_branch_eval
  import multicycle_sequencer_pkg::*;
(
  input  logic [3:0] opcode_i,
  input  logic       cmp_eq_i,
  input  logic       cmp_gt_i,
  input  logic       cmp_lt_i,
  output logic       taken_o
);

  always_comb begin
    taken_o = 1'b0;
    case (opcode_i)
      OP_BEQ:  taken_o = cmp_eq_i;
      OP_BGT:  taken_o = cmp_gt_i;
      OP_BLT:  taken_o = cmp_lt_i;
      OP_BGE:  taken_o = cmp_gt_i | cmp_eq_i;
      OP_BLE:  taken_o = cmp_lt_i | cmp_eq_i;
      default: taken_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_sequencer.sv
// Multi-cycle fetch/decode/execute/memory/writeback sequencer with memory
// wait timeout, sticky bus error and retired-instruction counter.
module multicycle_sequencer
  import multicycle_sequencer_pkg::*;
#(
  parameter int unsigned MAX_WAIT = 15,
  parameter int unsigned RET_W    = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             run,
  input  logic [17:0]      instruction,
  input  logic             instReady,
  input  logic             dataReady,
  input  logic             cmpEq,
  input  logic             cmpGt,
  input  logic             cmpLt,
  output logic             pcRead,
  output logic             instRead,
  output logic             pcInc,
  output logic             pcLoad,
  output logic [1:0]       aluOption,
  output logic             immSignal,
  output logic             compare,
  output logic             memLoad,
  output logic             memStore,
  output logic             registerWrite,
  output logic             halted,
  output logic             busError,
  output logic [2:0]       state,
  output logic [RET_W-1:0] retired
);

  // Last wait-counter value before the timeout fires.
  localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

  state_e           state_q, state_d;
  logic [3:0]       opcode_q, opcode_d;
  logic [7:0]       wait_q, wait_d;
  logic [RET_W-1:0] retired_q, retired_d;
  logic             bus_error_q, bus_error_d;
  logic             end_instr;
  logic             branch_taken;

  // Only the opcode field of the instruction word is consumed here.
  logic unused_inst_bits;
  assign unused_inst_bits = ^instruction[13:0];

  seq_branch_eval u_branch_eval (
    .opcode_i (opcode_q),
    .cmp_eq_i (cmpEq),
    .cmp_gt_i (cmpGt),
    .cmp_lt_i (cmpLt),
    .taken_o  (branch_taken)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      opcode_q    <= 4'd0;
      wait_q      <= 8'd0;
      retired_q   <= '0;
      bus_error_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      opcode_q    <= opcode_d;
      wait_q      <= wait_d;
      retired_q   <= retired_d;
      bus_error_q <= bus_error_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    opcode_d      = opcode_q;
    wait_d        = wait_q;
    bus_error_d   = bus_error_q;
    end_instr     = 1'b0;
    pcRead        = 1'b0;
    instRead      = 1'b0;
    pcInc         = 1'b0;
    pcLoad        = 1'b0;
    aluOption     = ALU_AND;
    immSignal     = 1'b0;
    compare       = 1'b0;
    memLoad       = 1'b0;
    memStore      = 1'b0;
    registerWrite = 1'b0;

    case (state_q)
      IDLE: begin
        if (run) begin
          state_d = FETCH;
          wait_d  = 8'd0;
        end
      end
      FETCH: begin
        pcRead   = 1'b1;
        instRead = 1'b1;
        // A ready in the cycle the timeout would fire still wins.
        if (instReady) begin
          pcInc    = 1'b1;
          opcode_d = instruction[17:14];
          state_d  = DECODE;
        end else if (wait_q == WAIT_LAST) begin
          state_d     = ERROR;
          bus_error_d = 1'b1;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      DECODE: state_d = EXECUTE;
      EXECUTE: begin
        if (is_alu_op(opcode_q)) begin
          aluOption = opcode_q[2:1];
          immSignal = opcode_q[0];
          state_d   = WRITEBACK;
        end else if (opcode_q == OP_LD || opcode_q == OP_ST) begin
          aluOption = ALU_ADD;
          immSignal = 1'b1;
          state_d   = MEMORY;
          wait_d    = 8'd0;
        end else if (opcode_q == OP_JUMP) begin
          pcLoad    = 1'b1;
          end_instr = 1'b1;
        end else begin
          compare   = 1'b1;
          pcLoad    = branch_taken;
          end_instr = 1'b1;
        end
      end
      MEMORY: begin
        aluOption = ALU_ADD;
        immSignal = 1'b1;
        memLoad   = (opcode_q == OP_LD);
        memStore  = (opcode_q == OP_ST);
        if (dataReady) begin
          if (opcode_q == OP_LD) state_d = WRITEBACK;
          else                   end_instr = 1'b1;
        end else if (wait_q == WAIT_LAST) begin
          state_d     = ERROR;
          bus_error_d = 1'b1;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      WRITEBACK: begin
        registerWrite = 1'b1;
        if (is_alu_op(opcode_q)) begin
          aluOption = opcode_q[2:1];
          immSignal = opcode_q[0];
        end
        end_instr = 1'b1;
      end
      ERROR:   state_d = ERROR;
      default: state_d = IDLE;
    endcase

    // run is only honoured at an instruction boundary.
    if (end_instr) begin
      state_d = run ? FETCH : IDLE;
      wait_d  = 8'd0;
    end
    retired_d = retired_q + RET_W'(end_instr);
  end

  assign halted   = (state_q == IDLE) || (state_q == ERROR);
  assign busError = bus_error_q;
  assign state    = state_q;
  assign retired  = retired_q;

endmodule
